wb_port_arbiter: RTL

- Shares the register file's single write port (regwrite / adr_wr_reg / wr_data) between two writeback producers: the ALU and the load unit (MEM).
- Arbitrates round-robin under contention and registers the winning write into a one-entry output stage.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/wb_port_arbiter_if.sv | 50 +++++
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: ALU/MEM writeback requests, decode scoreboard
// marks and hazard queries, and the register file write port.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              mark_valid;
  logic [ADDR_W-1:0] mark_rd;
  logic [ADDR_W-1:0] q_rs1;
  logic [ADDR_W-1:0] q_rs2;
  logic              hazard1;
  logic              hazard2;
  logic              regwrite;
  logic [ADDR_W-1:0] adr_wr_reg;
  logic [DATA_W-1:0] wr_data;
`ifdef WB_ARB_STATS_EN
  logic [15:0]       conflict_cnt;
`endif

  // Arbiter side: consumes requests and queries, drives the write port.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  mark_valid, mark_rd, q_rs1, q_rs2,
    output alu_ready, mem_ready, hazard1, hazard2,
`ifdef WB_ARB_STATS_EN
    output conflict_cnt,
`endif
    output regwrite, adr_wr_reg, wr_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output mark_valid, mark_rd, q_rs1, q_rs2,
    input  alu_ready, mem_ready, hazard1, hazard2,
`ifdef WB_ARB_STATS_EN
    input  conflict_cnt,
`endif
    input  regwrite, adr_wr_reg, wr_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin ALU/MEM arbiter for the register file write port, with a
// pending-write scoreboard for RAW hazards. WB_ARB_STATS_EN adds conflict_cnt.
module wb_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic              aluGrant;
  logic              memGrant;
  logic              xfer;
  logic [ADDR_W-1:0] xferRd;
  logic [DATA_W-1:0] xferData;

  logic              rrPtr_q, rrPtr_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] adrWrReg_q, adrWrReg_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic [NREGS-1:0]  pending_q, pending_d;

  // rrPtr_q=1 means MEM wins the next tie; grants are masked during reset.
  always_comb begin
    aluGrant = rst & bus.alu_valid & (~bus.mem_valid | ~rrPtr_q);
    memGrant = rst & bus.mem_valid & (~bus.alu_valid | rrPtr_q);
    xfer     = aluGrant | memGrant;
    xferRd   = aluGrant ? bus.alu_rd   : bus.mem_rd;
    xferData = aluGrant ? bus.alu_data : bus.mem_data;
  end

  always_comb begin
    rrPtr_d    = rrPtr_q;
    regwrite_d = 1'b0;
    adrWrReg_d = adrWrReg_q;
    wrData_d   = wrData_q;
    pending_d  = pending_q;

    if (aluGrant) begin
      rrPtr_d = 1'b1;
    end else if (memGrant) begin
      rrPtr_d = 1'b0;
    end

    // x0 writes are accepted but never reach the register file.
    if (xfer && (xferRd != '0)) begin
      regwrite_d = 1'b1;
      adrWrReg_d = xferRd;
      wrData_d   = xferData;
    end

    // Clear before set so a freshly issued producer keeps its bit.
    if (xfer) begin
      pending_d[xferRd] = 1'b0;
    end
    if (bus.mark_valid && (bus.mark_rd != '0)) begin
      pending_d[bus.mark_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rrPtr_q    <= 1'b0;
      regwrite_q <= 1'b0;
      adrWrReg_q <= '0;
      wrData_q   <= '0;
      pending_q  <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      regwrite_q <= regwrite_d;
      adrWrReg_q <= adrWrReg_d;
      wrData_q   <= wrData_d;
      pending_q  <= pending_d;
    end
  end

  // A write sitting in the output stage still counts as outstanding.
  always_comb begin
    bus.alu_ready  = aluGrant;
    bus.mem_ready  = memGrant;
    bus.regwrite   = regwrite_q;
    bus.adr_wr_reg = adrWrReg_q;
    bus.wr_data    = wrData_q;
    bus.hazard1    = (bus.q_rs1 != '0) &&
                     (pending_q[bus.q_rs1] || (regwrite_q && (adrWrReg_q == bus.q_rs1)));
    bus.hazard2    = (bus.q_rs2 != '0) &&
                     (pending_q[bus.q_rs2] || (regwrite_q && (adrWrReg_q == bus.q_rs2)));
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflictCnt_q, conflictCnt_d;

  always_comb begin
    conflictCnt_d = conflictCnt_q;
    if (bus.alu_valid && bus.mem_valid && (conflictCnt_q != 16'hFFFF)) begin
      conflictCnt_d = conflictCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflictCnt_q <= '0;
    end else begin
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign bus.conflict_cnt = conflictCnt_q;
`endif

endmodule
